// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and sizing helpers for the async FIFO read side
package fifo_pkg;
  localparam int RD_LAT_COMB = 0;
  localparam int RD_LAT_REG = 1;
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: credit-based FIFO read stage re-presenting data as a valid/ready stream
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OBUF_DEPTH = 4,
  parameter int RD_LAT = 1,
  localparam int CW = count_w(OBUF_DEPTH)
) (
  input  logic             r_clk,
  input  logic             rst_n,
  input  logic             empty,
  output logic             rd_rq,
  input  logic [WIDTH-1:0] rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CW-1:0]    obuf_count
);
  localparam int PW = $clog2(OBUF_DEPTH);
  typedef logic [WIDTH-1:0] data_t;
  if (OBUF_DEPTH < 2 || (OBUF_DEPTH & (OBUF_DEPTH - 1)) != 0 || OBUF_DEPTH < RD_LAT + 2) begin : g_bad_depth
    $error("fifo_rd_stream: OBUF_DEPTH must be a power of two and >= RD_LAT+2");
  end
  if (RD_LAT != RD_LAT_COMB && RD_LAT != RD_LAT_REG) begin : g_bad_lat
    $error("fifo_rd_stream: RD_LAT must be 0 or 1");
  end
  data_t mem_q [OBUF_DEPTH];
  data_t m_data_q, m_data_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic inflight_q, inflight_d, m_valid_q, m_valid_d, cap, pop;
  // The head is re-registered every edge; a word landing in an empty buffer is forwarded straight from rdata.
  always_comb begin
    rd_rq = rst_n && !empty && (count_q + CW'(inflight_q) < CW'(OBUF_DEPTH));
    inflight_d = (RD_LAT == RD_LAT_REG) && rd_rq;
    cap = (RD_LAT == RD_LAT_REG) ? inflight_q : rd_rq;
    pop = m_valid_q && m_ready;
    wr_ptr_d = wr_ptr_q + PW'(cap);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + CW'(cap) - CW'(pop);
    m_valid_d = count_d != '0;
    m_data_d = !m_valid_d ? m_data_q : (cap && wr_ptr_q == rd_ptr_d) ? rdata : mem_q[rd_ptr_d];
  end
  always_ff @(posedge r_clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      inflight_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      inflight_q <= inflight_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
    end
  always_ff @(posedge r_clk)
    if (cap) mem_q[wr_ptr_q] <= rdata;
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign obuf_count = count_q;
  a_no_overflow: assert property (@(posedge r_clk) disable iff (!rst_n)
    !(cap && !pop && count_q == CW'(OBUF_DEPTH)));
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: FIFO emulator plus queue model checking fifo_rd_stream every cycle
module tb_fifo_rd_stream;
  logic clk = 1'b0, rst_n = 1'b1, empty = 1'b1, m_ready = 1'b0, sel = 1'b0;
  logic [7:0] rdata = 8'hAA;
  logic rq0, rq1, v0, v1;
  logic [7:0] d0, d1;
  logic [2:0] c0;
  logic [1:0] c1;
  logic rd_rq_s, m_valid_s;
  logic [7:0] m_data_s;
  logic [31:0] cnt_s;
  fifo_rd_stream #(.WIDTH(8), .OBUF_DEPTH(4), .RD_LAT(1)) u_l1 (
    .r_clk(clk), .rst_n(rst_n), .empty(empty), .rd_rq(rq0), .rdata(rdata),
    .m_valid(v0), .m_ready(m_ready), .m_data(d0), .obuf_count(c0));
  fifo_rd_stream #(.WIDTH(8), .OBUF_DEPTH(2), .RD_LAT(0)) u_l0 (
    .r_clk(clk), .rst_n(rst_n), .empty(empty), .rd_rq(rq1), .rdata(rdata),
    .m_valid(v1), .m_ready(m_ready), .m_data(d1), .obuf_count(c1));
  assign rd_rq_s = sel ? rq1 : rq0;
  assign m_valid_s = sel ? v1 : v0;
  assign m_data_s = sel ? d1 : d0;
  assign cnt_s = sel ? 32'(c1) : 32'(c0);
  always #5 clk = ~clk;
  logic [7:0] src[$], ob[$], got[$], exp_q[$];
  logic [7:0] pend = '0, shown = '0, e_data = '0;
  bit pend_v = 0, e_rdrq = 0, e_valid = 0, chk_en = 0;
  int e_cnt = 0, lat = 1, dep = 4, cyc_n = 0, n_rdrq = 0, first_rq = -1, first_v = -1;
  int vectors = 0, miscompares = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("rd_rq", rd_rq_s, e_rdrq);
    chk("m_valid", m_valid_s, e_valid);
    chk("m_data", m_data_s, e_data);
    chk("obuf_count", cnt_s, e_cnt);
    if (rd_rq_s) n_rdrq++;
    if (rd_rq_s && first_rq < 0) first_rq = cyc_n;
    if (m_valid_s && first_v < 0) first_v = cyc_n;
    if (m_valid_s && m_ready) got.push_back(m_data_s);
  end
  // One cycle of FIFO emulation: drive inputs, predict outputs, then advance the model at the edge.
  task automatic cyc(input bit bub, input bit rdy);
    m_ready = rdy;
    empty = bub || src.size() == 0;
    if (lat == 1) begin
      if (pend_v) rdata = pend;
    end else if (src.size() != 0) rdata = src[0];
    e_rdrq = rst_n && !empty && (ob.size() + pend_v < dep);
    e_valid = ob.size() != 0;
    if (e_valid) shown = ob[0];
    e_data = shown;
    e_cnt = ob.size();
    @(posedge clk);
    cyc_n++;
    if (rst_n) begin
      if (e_valid && rdy) void'(ob.pop_front());
      if (lat == 1) begin
        if (pend_v) ob.push_back(pend);
        pend_v = e_rdrq;
        if (e_rdrq) pend = src.pop_front();
      end else if (e_rdrq) ob.push_back(src.pop_front());
    end
    #1;
  endtask
  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) src.push_back(8'(base + i));
  endtask
  task automatic expect_run(input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'(base + i));
  endtask
  task automatic chk_seq(input string nm);
    chk({nm, " beats"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(nm, got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst m_valid", m_valid_s, 0);
    chk("rst obuf_count", cnt_s, 0);
    chk("rst m_data", m_data_s, 0);
    chk("rst rd_rq", rd_rq_s, 0);
    src.delete();
    ob.delete();
    got.delete();
    pend_v = 0;
    shown = '0;
    e_rdrq = 0;
    e_valid = 0;
    e_data = '0;
    e_cnt = 0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1;
    load(8'h10, 16);
    for (int k = 0; k < 3; k++) cyc(0, 1);
    chk("reset rd_rq", rd_rq_s, 0);
    chk("reset m_data", m_data_s, 8'h00);
    // Release and stream 16 words with m_ready held high.
    rst_n = 1'b1;
    #0;
    chk("rd_rq after release", rd_rq_s, 1);
    first_rq = -1;
    first_v = -1;
    for (int k = 0; k < 22; k++) cyc(0, 1);
    chk("stream latency", 32'(first_v - first_rq), 2);
    expect_run(8'h10, 16);
    chk_seq("stream data");
    load(8'h10, 16);
    n_rdrq = 0;
    for (int k = 0; k < 10; k++) cyc(0, 0);
    chk("bp rd_rq cycles", n_rdrq, 4);
    chk("bp obuf_count", cnt_s, 4);
    chk("bp m_data", m_data_s, 8'h10);
    cyc(0, 1);
    chk("bp rd_rq resume", rd_rq_s, 1);
    for (int k = 0; k < 20; k++) cyc(0, 1);
    expect_run(8'h10, 16);
    chk_seq("bp data");
    load(8'h40, 24);
    for (int k = 0; k < 80; k++) cyc(((k / 3) % 2) == 0, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 40 && (ob.size() != 0 || pend_v || src.size() != 0); k++) cyc(0, 1);
    cyc(0, 1);
    expect_run(8'h40, 24);
    chk_seq("bubble data");
    load(8'h60, 4);
    for (int k = 0; k < 20 && !(ob.size() == 3 && pend_v); k++) cyc(0, 0);
    chk("midop obuf_count", cnt_s, 3);
    async_reset();
    cyc(0, 1);
    rst_n = 1'b1;
    load(8'h70, 4);
    for (int k = 0; k < 10; k++) cyc(0, 1);
    expect_run(8'h70, 4);
    chk_seq("post-reset data");
    sel = 1'b1;
    lat = 0;
    dep = 2;
    async_reset();
    rst_n = 1'b1;
    first_rq = -1;
    first_v = -1;
    load(8'h5A, 1);
    for (int k = 0; k < 4; k++) cyc(0, 0);
    chk("lat0 latency", 32'(first_v - first_rq), 1);
    chk("lat0 m_data", m_data_s, 8'h5A);
    chk("lat0 obuf_count", cnt_s, 1);
    load(8'h80, 8);
    for (int k = 0; k < 8; k++) cyc(0, (k % 2) == 0);
    for (int k = 0; k < 14; k++) cyc(0, 1);
    expect_run(8'h5A, 1);
    expect_run(8'h80, 8);
    chk_seq("lat0 data");
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
